// File: rtl/wdt_svc_pkg.sv
// Shared definitions for the watchdog service controller: op codes, register map,
// control bits, FSM states and bus-beat helpers.
package wdt_svc_pkg;

    typedef enum logic [1:0] {
        OP_KICK   = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_STATUS = 2'b10,
        OP_ARM    = 2'b11
    } wd_op_e;

    localparam logic [2:0] WD_STATUS  = 3'd0;
    localparam logic [2:0] WD_CONTROL = 3'd1;
    localparam logic [2:0] WD_PERIODL = 3'd2;
    localparam logic [2:0] WD_PERIODH = 3'd3;

    localparam int CTRL_IE_BIT    = 0;
    localparam int CTRL_START_BIT = 2;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_READ   = 3'd3,
        ST_RDWAIT = 3'd4,
        ST_DONE   = 3'd5
    } svc_state_e;

    typedef struct packed {
        logic        cs;
        logic        wr_n;
        logic [2:0]  addr;
        logic [15:0] data;
    } wd_bus_t;

    localparam wd_bus_t BUS_IDLE = '{cs: 1'b0, wr_n: 1'b1, addr: 3'd0, data: 16'h0000};

    function automatic logic [15:0] ctrl_arm_word(input logic irq_en);
        logic [15:0] w;
        w = 16'h0000;
        w[CTRL_START_BIT] = 1'b1;
        w[CTRL_IE_BIT]    = irq_en;
        return w;
    endfunction

    function automatic wd_bus_t bus_write(input logic [2:0] addr, input logic [15:0] data);
        return '{cs: 1'b1, wr_n: 1'b0, addr: addr, data: data};
    endfunction

    function automatic wd_bus_t bus_read(input logic [2:0] addr);
        return '{cs: 1'b1, wr_n: 1'b1, addr: addr, data: 16'h0000};
    endfunction

endpackage

// File: rtl/wdt_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner; the pointer moves
// only when the grant is taken.
module wdt_rr_arbiter #(
    parameter int  N_REQ = 2,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             grant_en,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] idx_s;
    logic [IDX_W-1:0] cand_idx_s;
    logic [N_REQ-1:0] grant_s;
    logic             found_s;
    int               cand_s;

    // First requester at or after the pointer, wrapping at N_REQ
    always_comb begin
        found_s    = 1'b0;
        idx_s      = '0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_s = int'(ptr_r) + i;
            if (cand_s >= N_REQ) begin
                cand_s = cand_s - N_REQ;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = IDX_W'(cand_s);
            if (!found_s && req[cand_idx_s]) begin
                found_s = 1'b1;
                idx_s   = cand_idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot form of the selected index
    always_comb begin
        grant_s = '0;
        if (found_s) begin
            grant_s[idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Priority pointer: index after the last winner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r <= '0;
        end else if (grant_en && found_s) begin
            ptr_r <= (idx_s == IDX_W'(N_REQ - 1)) ? '0 : idx_s + IDX_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign grant       = grant_s;
    assign grant_idx   = idx_s;
    assign grant_valid = found_s;

endmodule

// File: rtl/wdt_service_ctrl.sv
// Watchdog service sequencer: boot-time arm, round-robin single-beat ops to the
// watchdog register slave, late-kick detection and timeout counting.
module wdt_service_ctrl
    import wdt_svc_pkg::*;
#(
    parameter int   N_REQ       = 2,
    parameter int   KICK_WINDOW = 16000000,
    parameter int   WIN_W       = 25,
    parameter logic IRQ_EN      = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] req_op,
    output logic [N_REQ-1:0]   ack,
    output logic [1:0]         rsp_status,
    output logic               boot_done,
    output logic               kick_late,
    output logic [7:0]         timeout_count,
    output logic [2:0]         wd_address,
    output logic               wd_chipselect,
    output logic               wd_write_n,
    output logic [15:0]        wd_writedata,
    input  logic [15:0]        wd_readdata,
    input  logic               wd_timeout_pulse
);

    localparam int               IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(KICK_WINDOW);

    svc_state_e       state_r;
    wd_bus_t          bus_r;
    wd_op_e           op_r;
    wd_op_e           op_s;
    logic [N_REQ-1:0] win_oh_r;
    logic [N_REQ-1:0] ack_r;
    logic [1:0]       rsp_status_r;
    logic             boot_done_r;
    logic [WIN_W-1:0] kick_cnt_r;
    logic [WIN_W-1:0] kick_cnt_nxt_s;
    logic             kick_late_r;
    logic [7:0]       tmo_cnt_r;
    logic [7:0]       tmo_cnt_nxt_s;

    logic [N_REQ-1:0] grant_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic             grant_valid_s;
    logic             grant_en_s;
    logic [1:0]       op_arr_s [N_REQ];
    logic             unused_rd_s;

    assign unused_rd_s = ^wd_readdata[15:2];
    assign grant_en_s  = (state_r == ST_IDLE);

    wdt_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .grant_en    (grant_en_s),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    for (genvar g = 0; g < N_REQ; g++) begin : g_op
        assign op_arr_s[g] = req_op[2*g+1:2*g];
    end

    // Op of the requester the arbiter currently selects
    always_comb begin
        op_s = wd_op_e'(op_arr_s[grant_idx_s]);
    end

    // Sequencer: bus beat and ack are registered on entry to the state that shows them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_BOOT;
            bus_r        <= BUS_IDLE;
            op_r         <= OP_KICK;
            win_oh_r     <= '0;
            ack_r        <= '0;
            rsp_status_r <= 2'b00;
            boot_done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    bus_r   <= bus_write(WD_CONTROL, ctrl_arm_word(IRQ_EN));
                    ack_r   <= '0;
                    state_r <= ST_IDLE;
                end
                ST_IDLE: begin
                    boot_done_r <= 1'b1;
                    ack_r       <= '0;
                    if (grant_valid_s) begin
                        win_oh_r <= grant_s;
                        op_r     <= op_s;
                        case (op_s)
                            OP_STATUS: begin
                                bus_r   <= bus_read(WD_STATUS);
                                state_r <= ST_READ;
                            end
                            OP_CLEAR: begin
                                bus_r   <= bus_write(WD_STATUS, 16'h0000);
                                state_r <= ST_WRITE;
                            end
                            OP_ARM: begin
                                bus_r   <= bus_write(WD_CONTROL, ctrl_arm_word(IRQ_EN));
                                state_r <= ST_WRITE;
                            end
                            default: begin
                                // Any write to the period register reloads the counter
                                bus_r   <= bus_write(WD_PERIODL, 16'h0000);
                                state_r <= ST_WRITE;
                            end
                        endcase
                    end else begin
                        bus_r   <= BUS_IDLE;
                        state_r <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    bus_r   <= BUS_IDLE;
                    ack_r   <= win_oh_r;
                    state_r <= ST_DONE;
                end
                ST_READ: begin
                    bus_r   <= BUS_IDLE;
                    state_r <= ST_RDWAIT;
                end
                ST_RDWAIT: begin
                    bus_r        <= BUS_IDLE;
                    rsp_status_r <= wd_readdata[1:0];
                    ack_r        <= win_oh_r;
                    state_r      <= ST_DONE;
                end
                ST_DONE: begin
                    bus_r   <= BUS_IDLE;
                    ack_r   <= '0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    bus_r   <= BUS_IDLE;
                    ack_r   <= '0;
                    state_r <= ST_BOOT;
                end
            endcase
        end
    end

    // Kick window: a KICK entering DONE clears, which takes precedence over saturation
    always_comb begin
        if (state_r == ST_WRITE && op_r == OP_KICK) begin
            kick_cnt_nxt_s = '0;
        end else if (boot_done_r && kick_cnt_r != WIN_MAX) begin
            kick_cnt_nxt_s = kick_cnt_r + WIN_W'(1);
        end else begin
            kick_cnt_nxt_s = kick_cnt_r;
        end
    end

    // Saturating timeout event count
    always_comb begin
        if (wd_timeout_pulse && tmo_cnt_r != 8'hFF) begin
            tmo_cnt_nxt_s = tmo_cnt_r + 8'd1;
        end else begin
            tmo_cnt_nxt_s = tmo_cnt_r;
        end
    end

    // Monitor registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kick_cnt_r  <= '0;
            kick_late_r <= 1'b0;
            tmo_cnt_r   <= 8'h00;
        end else begin
            kick_cnt_r  <= kick_cnt_nxt_s;
            kick_late_r <= (kick_cnt_nxt_s == WIN_MAX);
            tmo_cnt_r   <= tmo_cnt_nxt_s;
        end
    end

    assign ack           = ack_r;
    assign rsp_status    = rsp_status_r;
    assign boot_done     = boot_done_r;
    assign kick_late     = kick_late_r;
    assign timeout_count = tmo_cnt_r;
    assign wd_address    = bus_r.addr;
    assign wd_chipselect = bus_r.cs;
    assign wd_write_n    = bus_r.wr_n;
    assign wd_writedata  = bus_r.data;

endmodule

// File: tb/tb_wdt_service_ctrl.sv
// Scoreboard bench for wdt_service_ctrl: directed ops push expected bus beats and
// acks (with cycle stamps); negedge monitors pop and compare.
module tb_wdt_service_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [3:0]  req_op = 4'b0000;
    logic [1:0]  ack;
    logic [1:0]  rsp_status;
    logic        boot_done;
    logic        kick_late;
    logic [7:0]  timeout_count;
    logic [2:0]  wd_address;
    logic        wd_chipselect;
    logic        wd_write_n;
    logic [15:0] wd_writedata;
    logic [15:0] wd_readdata = 16'h0000;
    logic        wd_timeout_pulse = 1'b0;
    logic [15:0] model_status = 16'h0000;

    always #5 clk = ~clk;

    wdt_service_ctrl #(.N_REQ(2), .KICK_WINDOW(20), .WIN_W(8), .IRQ_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_op(req_op), .ack(ack),
        .rsp_status(rsp_status), .boot_done(boot_done), .kick_late(kick_late),
        .timeout_count(timeout_count), .wd_address(wd_address),
        .wd_chipselect(wd_chipselect), .wd_write_n(wd_write_n),
        .wd_writedata(wd_writedata), .wd_readdata(wd_readdata),
        .wd_timeout_pulse(wd_timeout_pulse)
    );

    int cyc = 0;
    always @(posedge clk) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Watchdog slave model: status read registered, one-cycle latency
    always @(posedge clk) begin
        if (wd_chipselect && wd_write_n && wd_address == 3'd0) wd_readdata <= model_status;
    end

    typedef struct {int c; logic wr_n; logic [2:0] addr; logic [15:0] data;} bus_exp_t;
    typedef struct {int c; logic [1:0] ack; logic [1:0] st;} ack_exp_t;
    bus_exp_t bus_q[$];
    ack_exp_t ack_q[$];
    bus_exp_t be;
    ack_exp_t ae;
    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_bus(input int c, input logic wr_n, input logic [2:0] a, input logic [15:0] d);
        bus_q.push_back('{c: c, wr_n: wr_n, addr: a, data: d});
    endtask

    task automatic exp_ack(input int c, input logic [1:0] a, input logic [1:0] st);
        ack_q.push_back('{c: c, ack: a, st: st});
    endtask

    task automatic to_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            n_cmp++;
            n_fail++;
            $display("FAIL schedule: actual cycle=%0d required=%0d", cyc, n);
        end
    endtask

    // Bus and ack monitors
    always @(negedge clk) begin
        if (reset_n) begin
            if (wd_chipselect) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected_cs", {31'd0, wd_chipselect}, 32'd0);
                end else begin
                    be = bus_q.pop_front();
                    chk("bus_cycle", cyc, be.c);
                    chk("bus_write_n", {31'd0, wd_write_n}, {31'd0, be.wr_n});
                    chk("bus_addr", {29'd0, wd_address}, {29'd0, be.addr});
                    chk("bus_data", {16'd0, wd_writedata}, {16'd0, be.data});
                end
            end else begin
                chk("bus_idle", {12'd0, wd_write_n, wd_address, wd_writedata},
                    {12'd0, 1'b1, 3'd0, 16'h0000});
            end
            if (ack != 2'b00) begin
                if (ack_q.size() == 0) begin
                    chk("ack_unexpected", {30'd0, ack}, 32'd0);
                end else begin
                    ae = ack_q.pop_front();
                    chk("ack_cycle", cyc, ae.c);
                    chk("ack_vector", {30'd0, ack}, {30'd0, ae.ack});
                    chk("ack_rsp_status", {30'd0, rsp_status}, {30'd0, ae.st});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ack", {30'd0, ack}, 32'd0);
        chk("rst_rsp_status", {30'd0, rsp_status}, 32'd0);
        chk("rst_boot_done", {31'd0, boot_done}, 32'd0);
        chk("rst_kick_late", {31'd0, kick_late}, 32'd0);
        chk("rst_timeout_count", {24'd0, timeout_count}, 32'd0);
        chk("rst_bus", {11'd0, wd_chipselect, wd_write_n, wd_address, wd_writedata},
            {11'd0, 1'b0, 1'b1, 3'd0, 16'h0000});

        // Boot arm write in cycle 1, boot_done from cycle 2
        exp_bus(1, 1'b0, 3'd1, 16'h0005);
        reset_n = 1'b1;
        to_cyc(1);
        chk("boot_done_in_boot", {31'd0, boot_done}, 32'd0);
        to_cyc(2);
        chk("boot_done_after", {31'd0, boot_done}, 32'd1);
        to_cyc(21);
        chk("kick_late_before_window", {31'd0, kick_late}, 32'd0);
        to_cyc(22);
        chk("kick_late_at_window", {31'd0, kick_late}, 32'd1);

        // KICK from requester 0
        to_cyc(24);
        req_op = {2'b00, 2'b00}; req = 2'b01;
        exp_bus(25, 1'b0, 3'd2, 16'h0000);
        exp_ack(26, 2'b01, 2'b00);
        to_cyc(25);
        chk("kick_late_during_kick", {31'd0, kick_late}, 32'd1);
        to_cyc(26);
        chk("kick_late_cleared_done", {31'd0, kick_late}, 32'd0);
        req = 2'b00;

        // Two STATUS reads from requester 1
        to_cyc(28);
        model_status = 16'hABC2;
        req_op = {2'b10, 2'b00}; req = 2'b10;
        exp_bus(29, 1'b1, 3'd0, 16'h0000);
        exp_ack(31, 2'b10, 2'b10);
        to_cyc(30);
        chk("rdwait_addr", {29'd0, wd_address}, 32'd0);
        to_cyc(31);
        req = 2'b00;
        to_cyc(34);
        model_status = 16'h0003;
        req = 2'b10;
        exp_bus(35, 1'b1, 3'd0, 16'h0000);
        exp_ack(37, 2'b10, 2'b11);
        to_cyc(37);
        req = 2'b00;

        // Both requesters KICK, held: grants alternate 0,1,0,1
        to_cyc(40);
        req_op = {2'b00, 2'b00}; req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_bus(41 + 3*k, 1'b0, 3'd2, 16'h0000);
            exp_ack(42 + 3*k, (k % 2 == 0) ? 2'b01 : 2'b10, 2'b11);
        end
        to_cyc(51);
        req = 2'b00;

        // ARM from requester 0
        to_cyc(54);
        req_op = {2'b00, 2'b11}; req = 2'b01;
        exp_bus(55, 1'b0, 3'd1, 16'h0005);
        exp_ack(56, 2'b01, 2'b11);
        to_cyc(56);
        req = 2'b00;

        to_cyc(70);
        chk("kick_late_before_window2", {31'd0, kick_late}, 32'd0);
        to_cyc(71);
        chk("kick_late_at_window2", {31'd0, kick_late}, 32'd1);

        // 300 timeout pulses, saturating at 255
        for (int i = 0; i < 300; i++) begin
            wd_timeout_pulse = 1'b1;
            @(negedge clk);
            wd_timeout_pulse = 1'b0;
            @(negedge clk);
            if (i == 99) chk("timeout_count_100", {24'd0, timeout_count}, 32'd100);
        end
        chk("timeout_count_sat", {24'd0, timeout_count}, 32'd255);
        chk("kick_late_saturated", {31'd0, kick_late}, 32'd1);

        // CLEAR from requester 0, reset asserted during its write beat
        req_op = {2'b00, 2'b01}; req = 2'b01;
        @(posedge clk);
        #1;
        chk("clear_write_beat", {27'd0, wd_chipselect, wd_write_n, wd_address},
            {27'd0, 1'b1, 1'b0, 3'd0});
        #1 reset_n = 1'b0;
        #1;
        chk("reset_bus_idle", {11'd0, wd_chipselect, wd_write_n, wd_address, wd_writedata},
            {11'd0, 1'b0, 1'b1, 3'd0, 16'h0000});
        chk("reset_no_ack", {30'd0, ack}, 32'd0);
        req = 2'b00;
        repeat (2) @(negedge clk);
        chk("reset2_ack", {30'd0, ack}, 32'd0);
        chk("reset2_boot_done", {31'd0, boot_done}, 32'd0);
        chk("reset2_timeout_count", {24'd0, timeout_count}, 32'd0);
        chk("reset2_kick_late", {31'd0, kick_late}, 32'd0);
        chk("reset2_rsp_status", {30'd0, rsp_status}, 32'd0);

        // Re-boot, then priority must be back at index 0
        exp_bus(1, 1'b0, 3'd1, 16'h0005);
        reset_n = 1'b1;
        to_cyc(3);
        req_op = {2'b00, 2'b00}; req = 2'b11;
        exp_bus(4, 1'b0, 3'd2, 16'h0000);
        exp_ack(5, 2'b01, 2'b00);
        exp_bus(7, 1'b0, 3'd2, 16'h0000);
        exp_ack(8, 2'b10, 2'b00);
        to_cyc(8);
        req = 2'b00;

        repeat (6) @(negedge clk);
        chk("bus_queue_drained", bus_q.size(), 32'd0);
        chk("ack_queue_drained", ack_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
